bcd_convert_arbiter: RTL

Multi-cycle, shared binary-to-BCD converter for HUD numerals: score, high score, level counter. Several display requesters share one iterative double-dabble engine. A round-robin arbiter selects a requester, and the engine processes one binary bit per clock. The block returns four BCD digits with a one-cycle acknowledge to the winning requester. It sits between the game-state registers and the seven-segment/tile text renderers, replacing per-consumer combinational converters.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_dabble_step.sv | 25 ++
 rtl/bcd_convert_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types for the HUD binary-to-BCD converter: digit type, FSM encoding
// and the decimal limit helper used for saturation.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic longint unsigned bcd_limit(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// accumulator left by one with bit_in entering digit 0; top carry is dropped.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS
) (
  input  bcd_digit_t [DIGITS-1:0] acc_in,
  input  logic                    bit_in,
  output bcd_digit_t [DIGITS-1:0] acc_out
);

  bcd_digit_t [DIGITS-1:0] adj;

  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[d] = (acc_in[d] >= 4'd5) ? acc_in[d] + 4'd3 : acc_in[d];
    end
  end

  // The size cast truncates the carry out of the most significant digit.
  assign acc_out = (4*DIGITS)'({adj, bit_in});

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared binary-to-BCD converter, one bit per clock.
// Optional saturation to all-nines on overflow: BCD_CONVERT_OVERFLOW_SAT_EN.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int DIGITS  = BCD_DIGITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_value,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              busy,
  output bcd_digit_t [DIGITS-1:0]           bcd,
  output logic [$clog2(NUM_REQ)-1:0]        out_id,
  output logic                              overflow
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH);

  bcd_state_e              state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         owner;
  logic [CNT_W-1:0]        bit_cnt;
  logic [WIDTH-1:0]        sr;
  bcd_digit_t [DIGITS-1:0] acc;
  bcd_digit_t [DIGITS-1:0] acc_next;
  bcd_digit_t [DIGITS-1:0] result;
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;

  // First pending request at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .acc_in  (acc),
    .bit_in  (sr[WIDTH-1]),
    .acc_out (acc_next)
  );

  assign busy = (state != IDLE);

`ifdef BCD_CONVERT_OVERFLOW_SAT_EN
  localparam longint unsigned LIMIT = bcd_limit(DIGITS);

  logic ovf_cap;

  function automatic logic [4*DIGITS-1:0] sat_nines();
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign result = ovf_cap ? sat_nines() : acc;
`else
  assign result = acc;
`endif

  // Datapath: value capture at grant, then one dabble step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      sr  <= req_value[grant_id];
      acc <= '0;
`ifdef BCD_CONVERT_OVERFLOW_SAT_EN
      ovf_cap <= 64'(req_value[grant_id]) > LIMIT;
`endif
    end else if (state == SHIFT) begin
      sr  <= sr << 1;
      acc <= acc_next;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      bit_cnt <= '0;
      ack     <= '0;
      bcd     <= '0;
      out_id  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner   <= grant_id;
            bit_cnt <= CNT_W'(WIDTH-1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          bcd        <= result;
          out_id     <= owner;
          ack[owner] <= 1'b1;
          rr_ptr     <= (owner == ID_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_CONVERT_OVERFLOW_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (state == DONE) begin
      overflow <= ovf_cap;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
